// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: register map, CTRL bit
// positions, FSM state encoding and the default ID byte.
package spi_cmd_pkg;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_LED     = 3'd1;
  localparam logic [2:0] ADDR_LOAD    = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH = 3'd5;
  localparam logic [2:0] ADDR_RSVD    = 3'd6;
  localparam logic [2:0] ADDR_ID      = 3'd7;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Only these addresses accept writes; anything else raises STATUS.err.
  function automatic logic is_writable(input logic [2:0] addr);
    return (addr == ADDR_CTRL) || (addr == ADDR_LED) ||
           (addr == ADDR_LOAD) || (addr == ADDR_SCRATCH);
  endfunction

endpackage

// File: rtl/spi_cmd_regfile.sv
// Register file and read mux for the SPI command controller, including the
// sticky error flag and the frame counter reported through STATUS.
module spi_cmd_regfile
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = ID_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       status_rd,
  input  logic       frame_done,
  input  logic [7:0] cnt_value,
  output logic       cnt_en,
  output logic [4:0] leds,
  output logic [7:0] cnt_load_val
);

  logic       ctrl_en;
  logic [4:0] led_reg;
  logic [7:0] load_reg;
  logic [7:0] scratch_reg;
  logic       err;
  logic [3:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      led_reg     <= 5'h00;
      load_reg    <= 8'h00;
      scratch_reg <= 8'h00;
      err         <= 1'b0;
      frame_cnt   <= 4'h0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          ADDR_CTRL:    ctrl_en     <= wr_data[CTRL_EN_BIT];
          ADDR_LED:     led_reg     <= wr_data[4:0];
          ADDR_LOAD:    load_reg    <= wr_data;
          ADDR_SCRATCH: scratch_reg <= wr_data;
          default:      ;
        endcase
      end
      // A rejected write in the same cycle beats the read-to-clear.
      if (wr_en && !is_writable(wr_addr)) begin
        err <= 1'b1;
      end else if (status_rd) begin
        err <= 1'b0;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_CTRL:    rd_data = {7'b0, ctrl_en};
      ADDR_LED:     rd_data = {3'b0, led_reg};
      ADDR_LOAD:    rd_data = load_reg;
      ADDR_COUNT:   rd_data = cnt_value;
      ADDR_STATUS:  rd_data = {err, 3'b0, frame_cnt};
      ADDR_SCRATCH: rd_data = scratch_reg;
      ADDR_RSVD:    rd_data = 8'h00;
      ADDR_ID:      rd_data = ID_VALUE;
      default:      rd_data = 8'h00;
    endcase
  end

  assign cnt_en       = ctrl_en;
  assign leds         = led_reg;
  assign cnt_load_val = load_reg;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: first byte of a frame selects address and direction,
// following bytes burst-read or burst-write the register file.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = ID_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic [7:0] cnt_value,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic [4:0] leds,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       cnt_load,
  output logic [7:0] cnt_load_val
);

  state_t     state;
  logic [2:0] addr;
  logic       wr_mode;
  logic       armed;

  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_strobe;
  logic       wr_commit;
  logic       frame_done;
  logic       status_rd;

  // The byte being prepared for shifting out always belongs to the address
  // the next data byte will touch.
  assign rd_addr    = (state == CMD) ? rx_data[2:0] : addr + 3'd1;
  assign rd_strobe  = rx_valid && ((state == CMD) || ((state == DATA) && !wr_mode));
  assign wr_commit  = rx_valid && (state == DATA) && wr_mode;
  assign frame_done = (state == DATA) && !cs_active;
  assign status_rd  = rd_strobe && (rd_addr == ADDR_STATUS);

  spi_cmd_regfile #(
    .ID_VALUE(ID_VALUE)
  ) u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_commit),
    .wr_addr      (addr),
    .wr_data      (rx_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .status_rd    (status_rd),
    .frame_done   (frame_done),
    .cnt_value    (cnt_value),
    .cnt_en       (cnt_en),
    .leds         (leds),
    .cnt_load_val (cnt_load_val)
  );

  // armed records that chip select was low last cycle, so a frame already in
  // progress when reset releases is skipped until its next rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= 3'd0;
      wr_mode  <= 1'b0;
      armed    <= 1'b0;
      tx_data  <= 8'h00;
      tx_load  <= 1'b0;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
    end else begin
      tx_load  <= 1'b0;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      armed    <= ~cs_active;
      if (rd_strobe) begin
        tx_data <= rd_data;
        tx_load <= 1'b1;
      end
      if (wr_commit) begin
        cnt_clr  <= (addr == ADDR_CTRL) && rx_data[CTRL_CLR_BIT];
        cnt_load <= (addr == ADDR_LOAD);
      end
      case (state)
        IDLE: begin
          if (cs_active && armed) state <= CMD;
        end
        CMD: begin
          if (rx_valid) begin
            addr    <= rx_data[2:0];
            wr_mode <= rx_data[7];
          end
          if (!cs_active)    state <= IDLE;
          else if (rx_valid) state <= DATA;
        end
        DATA: begin
          if (rx_valid)   addr  <= addr + 3'd1;
          if (!cs_active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
